// File: rtl/fifo_sp_ctrl_pkg.sv
// Shared definitions for the single-port-SRAM FIFO controller: grant encoding
// and the ceil-log2 helper used to size pointers and counters.
package fifo_sp_ctrl_pkg;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } gnt_e;

  // Ceiling log2, never less than 1 so a 2-word SRAM still gets a 1-bit address.
  function automatic int func_log2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_ob_2e.sv
// Two-entry in-order output buffer between the SRAM read return and the pop
// stream; entry 0 is always the head.
module fifo_ob_2e #(
  parameter int DATA_WD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_val_i,
  input  logic [DATA_WD-1:0] cap_dat_i,
  output logic               pop_val_o,
  output logic [DATA_WD-1:0] pop_dat_o,
  input  logic               pop_rdy_i,
  output logic [1:0]         ob_cnt_o
);

  logic [DATA_WD-1:0] ent0_q, ent0_d;
  logic [DATA_WD-1:0] ent1_q, ent1_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               pop;

  assign pop = pop_rdy_i && (cnt_q != 2'd0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({cap_val_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = cap_dat_i;
        else               ent1_d = cap_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the capture lands behind whatever survives the pop.
        if (cnt_q == 2'd1) begin
          ent0_d = cap_dat_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = cap_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pop_val_o = (cnt_q != 2'd0);
  assign pop_dat_o = ent0_q;
  assign ob_cnt_o  = cnt_q;

endmodule

// File: rtl/fifo_sp_ctrl.sv
// FIFO controller sharing one single-port SRAM between pushes and prefetch reads.
// Optional simulation checker enabled by defining FIFO_SP_CTRL_CHK_EN.
module fifo_sp_ctrl
  import fifo_sp_ctrl_pkg::*;
#(
  parameter  int SIZE    = 32,
  parameter  int DATA_WD = 16,
  localparam int SIZE_WD = func_log2(SIZE),
  localparam int CNT_WD  = func_log2(SIZE + 2) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_val_i,
  input  logic [DATA_WD-1:0] push_dat_i,
  output logic               push_rdy_o,
  output logic               pop_val_o,
  output logic [DATA_WD-1:0] pop_dat_o,
  input  logic               pop_rdy_i,
  output logic [CNT_WD-1:0]  cnt_o,
  output logic [SIZE_WD-1:0] sram_adr_o,
  output logic               sram_wr_val_o,
  output logic [DATA_WD-1:0] sram_wr_dat_o,
  output logic               sram_rd_val_o,
  input  logic [DATA_WD-1:0] sram_rd_dat_i
);

  logic [SIZE_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [SIZE_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WD-1:0]  sram_cnt_q, sram_cnt_d;
  logic               rd_inflight_q, rd_inflight_d;
  gnt_e               last_gnt_q, last_gnt_d;
  logic [1:0]         ob_cnt;
  logic               rd_req, wr_gnt, rd_gnt;

  // The in-flight read already owns an output-buffer slot, so the buffer never overflows.
  assign rd_req     = (sram_cnt_q != '0) && (({1'b0, ob_cnt} + {2'b00, rd_inflight_q}) < 3'd2);
  assign push_rdy_o = (sram_cnt_q < CNT_WD'(SIZE)) && (!rd_req || (last_gnt_q == GNT_READ));
  assign wr_gnt     = push_val_i && push_rdy_o;
  assign rd_gnt     = rd_req && !wr_gnt;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    sram_cnt_d    = sram_cnt_q;
    last_gnt_d    = last_gnt_q;
    rd_inflight_d = rd_gnt;
    if (wr_gnt) begin
      wr_ptr_d   = (wr_ptr_q == SIZE_WD'(SIZE - 1)) ? '0 : wr_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q + 1'b1;
      last_gnt_d = GNT_WRITE;
    end else if (rd_gnt) begin
      rd_ptr_d   = (rd_ptr_q == SIZE_WD'(SIZE - 1)) ? '0 : rd_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q - 1'b1;
      last_gnt_d = GNT_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      last_gnt_q    <= GNT_READ;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sram_cnt_q    <= sram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      last_gnt_q    <= last_gnt_d;
    end
  end

  fifo_ob_2e #(
    .DATA_WD (DATA_WD)
  ) u_ob (
    .clk       (clk),
    .rst       (rst),
    .cap_val_i (rd_inflight_q),
    .cap_dat_i (sram_rd_dat_i),
    .pop_val_o (pop_val_o),
    .pop_dat_o (pop_dat_o),
    .pop_rdy_i (pop_rdy_i),
    .ob_cnt_o  (ob_cnt)
  );

  assign sram_adr_o    = wr_gnt ? wr_ptr_q : rd_ptr_q;
  assign sram_wr_val_o = wr_gnt;
  assign sram_wr_dat_o = push_dat_i;
  assign sram_rd_val_o = rd_gnt;
  assign cnt_o         = sram_cnt_q + CNT_WD'(rd_inflight_q) + CNT_WD'(ob_cnt);

`ifdef FIFO_SP_CTRL_CHK_EN
  int unsigned stall_q;
  logic        stall_hit, ovf_hit, x_hit;

  always_ff @(posedge clk) begin
    if (rst || !(push_val_i && !push_rdy_o)) stall_q <= 0;
    else                                     stall_q <= stall_q + 1;
  end

  assign stall_hit = push_val_i && !push_rdy_o && (stall_q >= 10000);
  assign ovf_hit   = (int'(cnt_o) > SIZE + 2);
  assign x_hit     = rd_inflight_q && $isunknown(sram_rd_dat_i);

  always @(posedge clk) begin
    if (!rst) begin
      if (stall_hit) $display("FIFO ERROR: push while not ready @%m");
      if (ovf_hit)   $display("FIFO ERROR: occupancy %0d exceeds SIZE+2 @%m", cnt_o);
      if (x_hit)     $display("FIFO ERROR: unknown bits in captured read data @%m");
      if (stall_hit || ovf_hit || x_hit) begin
        #1000;
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sp_ctrl.sv
// Scoreboard bench for fifo_sp_ctrl: a 32-word instance for fill, latency,
// reset and streaming vectors, and a 24-word instance for pointer wrap.
module tb_fifo_sp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_val [2];
  logic [15:0] push_dat [2];
  logic        push_rdy [2];
  logic        pop_val  [2];
  logic [15:0] pop_dat  [2];
  logic        pop_rdy  [2];
  logic [7:0]  cnt      [2];
  logic        wr_val   [2];
  logic        rd_val   [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int SZ = (gi == 0) ? 32 : 24;
    localparam int CW = (gi == 0) ? 7 : 6;

    logic [4:0]    adr;
    logic [15:0]   wr_dat;
    logic [15:0]   rd_dat;
    logic [CW-1:0] cnt_l;
    logic [15:0]   mem [SZ];
    logic [15:0]   sb_q [$];
    int            exp_wa  = 0;
    int            exp_ra  = 0;
    int            wrap_w  = 0;
    int            wrap_r  = 0;
    int            pop_cnt = 0;

    fifo_sp_ctrl #(
      .SIZE    (SZ),
      .DATA_WD (16)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .push_val_i    (push_val[gi]),
      .push_dat_i    (push_dat[gi]),
      .push_rdy_o    (push_rdy[gi]),
      .pop_val_o     (pop_val[gi]),
      .pop_dat_o     (pop_dat[gi]),
      .pop_rdy_i     (pop_rdy[gi]),
      .cnt_o         (cnt_l),
      .sram_adr_o    (adr),
      .sram_wr_val_o (wr_val[gi]),
      .sram_wr_dat_o (wr_dat),
      .sram_rd_val_o (rd_val[gi]),
      .sram_rd_dat_i (rd_dat)
    );

    assign cnt[gi] = 8'(cnt_l);

    // Single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
      if (wr_val[gi]) mem[adr] <= wr_dat;
      if (rd_val[gi]) rd_dat   <= mem[adr];
    end

    // Monitor: record accepted pushes, check SRAM addressing, compare pops.
    initial forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        exp_wa = 0;
        exp_ra = 0;
      end else begin
        if (wr_val[gi] || rd_val[gi])
          check("one_access", {31'b0, wr_val[gi] && rd_val[gi]}, 32'd0);
        if (wr_val[gi]) begin
          check("wr_addr", 32'(adr), exp_wa);
          check("wr_data", 32'(wr_dat), 32'(push_dat[gi]));
          if (exp_wa == SZ - 1) wrap_w++;
          exp_wa = (exp_wa + 1) % SZ;
        end
        if (rd_val[gi]) begin
          check("rd_addr", 32'(adr), exp_ra);
          if (exp_ra == SZ - 1) wrap_r++;
          exp_ra = (exp_ra + 1) % SZ;
        end
        if (push_val[gi] && push_rdy[gi]) sb_q.push_back(push_dat[gi]);
        if (pop_val[gi] && pop_rdy[gi]) begin
          pop_cnt++;
          check("pop_expected", {31'b0, sb_q.size() > 0}, 32'd1);
          if (sb_q.size() > 0) check("pop_data", 32'(pop_dat[gi]), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int n;
    int p0;
    int alt_err;
    int spops;
    logic acc;
    logic prev_wr;

    for (int i = 0; i < 2; i++) begin
      push_val[i] = 1'b0;
      push_dat[i] = '0;
      pop_rdy[i]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_push_rdy", 32'(push_rdy[0]), 32'd1);
    check("rst_pop_val",  32'(pop_val[0]),  32'd0);
    check("rst_cnt",      32'(cnt[0]),      32'd0);
    check("rst_wr_val",   32'(wr_val[0]),   32'd0);
    check("rst_rd_val",   32'(rd_val[0]),   32'd0);
    check("rst_pop_dat",  32'(pop_dat[0]),  32'd0);
    check("rst_cnt_b",    32'(cnt[1]),      32'd0);
    cyc();

    // Fill: 0x0001..0x0028 offered with the consumer stalled.
    d = 1;
    for (int c = 0; c < 120; c++) begin
      push_val[0] = (d <= 40);
      push_dat[0] = 16'(d);
      @(negedge clk);
      acc = push_val[0] && push_rdy[0];
      cyc();
      if (acc) d++;
    end
    push_val[0] = 1'b0;
    @(negedge clk);
    check("fill_accepted", d - 1, 32'd34);
    check("fill_push_rdy", 32'(push_rdy[0]), 32'd0);
    check("fill_cnt",      32'(cnt[0]),      32'd34);
    p0 = g_dut[0].pop_cnt;
    cyc();
    pop_rdy[0] = 1'b1;
    repeat (100) cyc();
    @(negedge clk);
    check("drain_pops", g_dut[0].pop_cnt - p0, 32'd34);
    check("drain_cnt",  32'(cnt[0]), 32'd0);
    cyc();
    pop_rdy[0] = 1'b0;

    // Latency: push in cycle 0, read in cycle 1, data visible in cycle 3.
    push_val[0] = 1'b1;
    push_dat[0] = 16'hABCD;
    @(negedge clk);
    check("lat_c0_wr", 32'(wr_val[0]), 32'd1);
    check("lat_c0_rd", 32'(rd_val[0]), 32'd0);
    cyc();
    push_val[0] = 1'b0;
    @(negedge clk);
    check("lat_c1_rd", 32'(rd_val[0]), 32'd1);
    cyc();
    @(negedge clk);
    check("lat_c2_pop_val", 32'(pop_val[0]), 32'd0);
    cyc();
    pop_rdy[0] = 1'b1;
    @(negedge clk);
    check("lat_c3_pop_val", 32'(pop_val[0]), 32'd1);
    check("lat_c3_pop_dat", 32'(pop_dat[0]), 32'hABCD);
    cyc();
    pop_rdy[0] = 1'b0;
    @(negedge clk);
    check("lat_empty_cnt", 32'(cnt[0]), 32'd0);
    cyc();

    // Reset in the cycle after a read grant while one word sits in the buffer.
    push_val[0] = 1'b1;
    push_dat[0] = 16'h1111;
    cyc();
    push_val[0] = 1'b0;
    cyc();
    push_val[0] = 1'b1;
    push_dat[0] = 16'h2222;
    @(negedge clk);
    check("rmo_c2_wr", 32'(wr_val[0]), 32'd1);
    cyc();
    push_val[0] = 1'b0;
    @(negedge clk);
    check("rmo_c3_rd",      32'(rd_val[0]),  32'd1);
    check("rmo_c3_pop_val", 32'(pop_val[0]), 32'd1);
    check("rmo_c3_cnt",     32'(cnt[0]),     32'd2);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rmo_cnt",      32'(cnt[0]),      32'd0);
    check("rmo_pop_val",  32'(pop_val[0]),  32'd0);
    check("rmo_push_rdy", 32'(push_rdy[0]), 32'd1);
    pop_rdy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      @(negedge clk);
      check("rmo_no_data", 32'(pop_val[0]), 32'd0);
    end
    cyc();
    pop_rdy[0] = 1'b0;

    // Streaming: both sides always willing; port alternates W/R, one pop per 2 cycles.
    alt_err = 0;
    spops   = 0;
    prev_wr = 1'b0;
    d       = 0;
    pop_rdy[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      push_val[0] = 1'b1;
      push_dat[0] = 16'(32'h5000 + d);
      @(negedge clk);
      acc = push_val[0] && push_rdy[0];
      if (i >= 4 && (!(wr_val[0] ^ rd_val[0]) || (wr_val[0] == prev_wr))) alt_err++;
      prev_wr = wr_val[0];
      if (i >= 10 && i < 190 && pop_val[0] && pop_rdy[0]) spops++;
      cyc();
      if (acc) d++;
    end
    push_val[0] = 1'b0;
    check("stream_alternation_errs", alt_err, 32'd0);
    check("stream_pops_180cyc",      spops,   32'd90);
    repeat (20) cyc();
    @(negedge clk);
    check("stream_drain_cnt", 32'(cnt[0]), 32'd0);
    cyc();
    pop_rdy[0] = 1'b0;

    // Wrap: 24-word instance, 100 words under random valid/ready.
    n = 0;
    for (int c = 0; c < 4000; c++) begin
      if (n == 100 && cnt[1] == 8'd0) break;
      push_val[1] = (n < 100) && ($urandom_range(0, 3) != 0);
      push_dat[1] = 16'(32'h0100 + n);
      pop_rdy[1]  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = push_val[1] && push_rdy[1];
      cyc();
      if (acc) n++;
    end
    push_val[1] = 1'b0;
    pop_rdy[1]  = 1'b0;
    @(negedge clk);
    check("wrap_pushed",   n,                  32'd100);
    check("wrap_popped",   g_dut[1].pop_cnt,   32'd100);
    check("wrap_cnt",      32'(cnt[1]),        32'd0);
    check("wrap_wr_ge4",   {31'b0, g_dut[1].wrap_w >= 4}, 32'd1);
    check("wrap_rd_ge4",   {31'b0, g_dut[1].wrap_r >= 4}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sp_ctrl.md
Name: fifo_sp_ctrl

Overview:
Synchronous FIFO controller that drives an external single-port SRAM model. It accepts a valid/ready push stream and issues SRAM writes and reads over one shared port. It returns data through a 2-entry output prefetch buffer as a valid/ready pop stream. It is instantiated next to the SRAM in a parent wrapper; the SRAM has one-cycle read latency and capacity SIZE words.

Parameters:
SIZE, 32, SRAM depth in words; any value ≥ 2, power of two not required
DATA_WD, 16, data width in bits
SIZE_WD, FUNC_LOG2(SIZE), localparam; SRAM address and pointer width
CNT_WD, FUNC_LOG2(SIZE+2)+1, localparam; occupancy width, must hold SIZE+2

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
push_val_i  in  1  push request
push_dat_i  in  DATA_WD  push data
push_rdy_o  out  1  push accepted when push_val_i && push_rdy_o; independent of push_val_i
pop_val_o  out  1  output buffer holds data
pop_dat_o  out  DATA_WD  head of FIFO
pop_rdy_i  in  1  consumer takes the head when pop_val_o && pop_rdy_i
cnt_o  out  CNT_WD  total occupancy: SRAM + in-flight read + output buffer
sram_adr_o  out  SIZE_WD  SRAM address; combinational mux of wr_ptr/rd_ptr
sram_wr_val_o  out  1  SRAM write strobe (= push handshake)
sram_wr_dat_o  out  DATA_WD  = push_dat_i
sram_rd_val_o  out  1  SRAM read strobe
sram_rd_dat_i  in  DATA_WD  SRAM read data, valid the cycle after sram_rd_val_o

Behaviour:
- Reset (sync, active-high): wr_ptr=rd_ptr=0, sram_cnt=0, rd_inflight=0, ob_cnt=0, last_gnt=READ; outputs push_rdy_o=1, pop_val_o=0, cnt_o=0, sram_wr_val_o=0, sram_rd_val_o=0, pop_dat_o=0.
- A reset in the same cycle as sram_rd_dat_i return discards that data. A reset arriving mid-operation drops all contents.
- rd_req = (sram_cnt>0) && (ob_cnt + rd_inflight < 2).
- push_rdy_o = (sram_cnt<SIZE) && (!rd_req || last_gnt==READ).
- Write grant = push_val_i && push_rdy_o. Read grant = rd_req && !write grant. At most one port access per cycle.
- last_gnt updates only on a grant. When both sides contend, grants alternate, so each gets ≥ 1/2 port bandwidth.
- Write: sram_adr_o=wr_ptr. wr_ptr wraps SIZE-1→0 explicitly. sram_cnt+1.
- Read: sram_adr_o=rd_ptr. rd_ptr wraps likewise. sram_cnt-1. rd_inflight=1 next cycle, then sram_rd_dat_i is captured into ob.
- Idle cycle: sram_adr_o=rd_ptr, both strobes 0.
- Output buffer: 2-entry in-order register FIFO. pop_val_o=(ob_cnt>0) is registered, not combinational from sram_rd_dat_i. A capture and a pop in the same cycle keep ob_cnt unchanged.
- First-word latency on an empty FIFO: push accepted in cycle 0, read in cycle 1, captured at end of cycle 2, pop_val_o=1 in cycle 3.
- Full: sram_cnt==SIZE → push_rdy_o=0. Maximum cnt_o = SIZE+2.
- Empty: pop_val_o=0. A pop_rdy_i asserted while empty is ignored.
- Ordering is strict FIFO under all interleavings.

Optional Feature:
FIFO_SP_CTRL_CHK_EN, simulation only:
- With the macro defined, on each clk edge:
  - display "FIFO ERROR: push while not ready @%m" if push_val_i && !push_rdy_o is held for more than 10000 cycles (stall watchdog);
  - display an error if cnt_o > SIZE+2;
  - display an error if sram_rd_dat_i has X bits when captured;
  - then #1000 $finish.
- Without the macro, none of this logic exists and there is no port difference.

Decomposition:
- Shared define.vh: FUNC_LOG2; grant encoding constants GNT_READ/GNT_WRITE.
- One sub-module: fifo_ob_2e. It is the 2-entry output buffer with capture input, pop handshake, and ob_cnt output.
- Arbitration, pointers and counters stay in the top.

Test Plan:
- Fill: SIZE=32, pop_rdy_i=0, push 0x0001..0x0028 continuously → exactly 34 accepted, push_rdy_o then stays 0, cnt_o=34. Then pop_rdy_i=1 → pops 0x0001..0x0022 in order, cnt_o returns to 0.
- Latency: from empty, push 0xABCD in cycle 0 → sram_wr_val_o in cycle 0, sram_rd_val_o in cycle 1, pop_val_o=1 with pop_dat_o=0xABCD in cycle 3.
- Streaming: push_val_i=1 and pop_rdy_i=1 for 200 cycles → after warm-up, grants alternate W/R, one pop per 2 cycles, data order matches push order.
- Wrap: SIZE=24, push/pop 100 random words with random valid/ready → scoreboard matches, pointers pass 23→0 at least 4 times.
- Reset mid-op: assert rst in the cycle after a read grant, with ob_cnt=1 → next cycle cnt_o=0, pop_val_o=0, and the returning word never appears on pop_dat_o.
- Checker: with FIFO_SP_CTRL_CHK_EN defined, force sram_rd_dat_i=X on a capture → error message printed and simulation finishes. Without the macro, the run completes silently.
